// File: rtl/imem_pkg.sv
// Shared constants and helpers for the instruction-memory read-port arbiter.
// Addresses are byte addresses; the memory is indexed by 32-bit word.
package imem_pkg;

    localparam int          IMEM_DEPTH = 512;
    localparam int          IMEM_IDX_W = 9;
    localparam int          WAIT_W     = 4;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

    // A byte address is unusable if it is not word aligned or its word index is past the end.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles a debug request lost to fetch; raises
// starve_force once the count reaches MAX_WAIT so debug wins the next arbitration.
module imem_starve_ctr
    import imem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d_req,
    input  logic f_req,
    input  logic d_gnt,
    output logic starve_force
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!d_req || d_gnt) begin
            wait_cnt_nxt = '0;
        end else if (f_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    assign starve_force = d_req && (wait_cnt == WAIT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the single combinational instruction-memory read port:
// fetch has priority, debug is guaranteed a grant after MAX_WAIT lost cycles.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] ERR_WORD = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data
);

    // Handshake: a requester holds req and a stable addr until it sees gnt in the
    // same cycle; the matching rvalid is a one-cycle pulse on the following edge,
    // and rdata/err hold until that port's next rvalid. One grant per cycle.

    logic starve_force;
    logic rsp_err;
    logic [31:0] rsp_data;

    imem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .d_req        (d_req),
        .f_req        (f_req),
        .d_gnt        (d_gnt),
        .starve_force (starve_force)
    );

    always_comb begin
        d_gnt    = d_req && (!f_req || starve_force);
        f_gnt    = f_req && !d_gnt;
        mem_addr = d_gnt ? d_addr : f_addr;
    end

    // Error check runs on the muxed address, so it always matches the granted port.
    always_comb begin
        rsp_err  = addr_err(mem_addr, DEPTH);
        rsp_data = rsp_err ? ERR_WORD : mem_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rvalid <= 1'b0;
            f_rdata  <= '0;
            f_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            if (f_gnt) begin
                f_rdata <= rsp_data;
                f_err   <= rsp_err;
            end
            if (d_gnt) begin
                d_rdata <= rsp_data;
                d_err   <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: drivers push expected responses into per-port
// queues, a negedge monitor pops and compares whenever an rvalid pulse appears.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    logic [31:0] mem [512];
    logic [15:0] cycle_cnt = '0;

    // entry = {expected cycle[15:0], err, data[31:0]}
    logic [48:0] f_exp_q[$];
    logic [48:0] d_exp_q[$];

    int checks = 0;
    int failures = 0;

    imem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    assign mem_data = mem[mem_addr[10:2]];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 16'd1;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_rsp(input logic [31:0] a);
        logic bad;
        bad = (a[1:0] != 2'b00) || (a > 32'h0000_07FF);
        return bad ? 33'h1_0000_0000 : {1'b0, mem[a[10:2]]};
    endfunction

    // One arbitration cycle: drive after the edge, check grants, queue the expected response.
    task automatic drive(input logic fr, input logic [31:0] fa, input logic dr,
                         input logic [31:0] da, input logic exp_f, input logic exp_d);
        @(posedge clk);
        #2;
        f_req = fr; f_addr = fa; d_req = dr; d_addr = da;
        #1;
        check("f_gnt", 64'(f_gnt), 64'(exp_f));
        check("d_gnt", 64'(d_gnt), 64'(exp_d));
        if (exp_f) begin
            check("mem_addr_f", 64'(mem_addr), 64'(fa));
            f_exp_q.push_back({cycle_cnt + 16'd1, model_rsp(fa)});
        end
        if (exp_d) begin
            check("mem_addr_d", 64'(mem_addr), 64'(da));
            d_exp_q.push_back({cycle_cnt + 16'd1, model_rsp(da)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_f_rvalid"}, 64'(f_rvalid), 64'd0);
        check({tag, "_f_rdata"},  64'(f_rdata),  64'd0);
        check({tag, "_f_err"},    64'(f_err),    64'd0);
        check({tag, "_d_rvalid"}, 64'(d_rvalid), 64'd0);
        check({tag, "_d_rdata"},  64'(d_rdata),  64'd0);
        check({tag, "_d_err"},    64'(d_err),    64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [48:0] e;
        if (f_rvalid) begin
            if (f_exp_q.size() == 0) begin
                check("f_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = f_exp_q.pop_front();
                check("f_latency", 64'(cycle_cnt), 64'(e[48:33]));
                check("f_rsp", 64'({f_err, f_rdata}), 64'(e[32:0]));
            end
        end else if (f_exp_q.size() != 0 && f_exp_q[0][48:33] == cycle_cnt) begin
            e = f_exp_q.pop_front();
            check("f_missing_rvalid", 64'd0, 64'd1);
        end
        if (d_rvalid) begin
            if (d_exp_q.size() == 0) begin
                check("d_unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = d_exp_q.pop_front();
                check("d_latency", 64'(cycle_cnt), 64'(e[48:33]));
                check("d_rsp", 64'({d_err, d_rdata}), 64'(e[32:0]));
            end
        end else if (d_exp_q.size() != 0 && d_exp_q[0][48:33] == cycle_cnt) begin
            e = d_exp_q.pop_front();
            check("d_missing_rvalid", 64'd0, 64'd1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {16'hA5C3, 16'(i)};
        mem[0] = 32'h1111_0000;
        mem[1] = 32'h2222_0001;
        mem[2] = 32'h2008_0005;
        mem[511] = 32'hDEAD_01FF;

        // reset state
        #3;
        check_regs_zero("reset");
        check("reset_f_gnt", 64'(f_gnt), 64'd0);
        check("reset_d_gnt", 64'(d_gnt), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // 1: single fetch of word 2
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);

        // 4: back-to-back fetches 0,4,8
        drive(1'b1, 32'h0000_0000, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);

        // 3: debug-only misaligned, out of range, and last valid word
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0006, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0800, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 32'h0000_07FC, 1'b0, 1'b1);
        idle(2);
        // fetch response registers hold across debug traffic
        check("f_rdata_hold", 64'(f_rdata), 64'h2008_0005);
        check("f_err_hold",   64'(f_err),   64'd0);

        // fetch error: high address
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0);
        idle(2);

        // 2: both held high, pattern f,f,f,f,d,f,f,f,f,d
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                drive(1'b1, 32'(i * 4), 1'b1, 32'h0000_07FC, 1'b0, 1'b1);
            else
                drive(1'b1, 32'(i * 4), 1'b1, 32'h0000_07FC, 1'b1, 1'b0);
        end
        idle(2);

        // 6: blocked 3 cycles, dropped 1, then 4 more blocked before forced grant
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0014, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_0018, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0018, 1'b1, 32'h0000_0004, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_001C, 1'b1, 32'h0000_0008, 1'b1, 1'b0);
        idle(2);

        // 5: build the counter to 3, grant fetch, then reset asynchronously mid-cycle
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        f_req = 1'b1; f_addr = 32'h0000_0024; d_req = 1'b1; d_addr = 32'h0000_0004;
        #1;
        check("rst_cycle_f_gnt", 64'(f_gnt), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_regs_zero("rst_async");
        @(posedge clk);
        #2;
        f_req = 1'b0; d_req = 1'b0;
        #1;
        check_regs_zero("rst_held");
        @(posedge clk);
        #2 rst = 1'b0;
        // counter must restart from 0: four fetch wins before debug is forced
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_0028, 1'b1, 32'h0000_000C, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0028, 1'b1, 32'h0000_000C, 1'b0, 1'b1);
        idle(3);

        check("f_queue_drained", 64'(f_exp_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
